lt24_layer_blitter: RTL and testbench

LT24_LAYER_BLITTER -- requirements
Module: lt24_layer_blitter

---
 rtl/lt24_pkg.sv | 19 +
 rtl/lt24_phase_timer.sv | 25 ++
 rtl/lt24_layer_blitter.sv | 159 +++++++++++++++
 tb/tb_lt24_layer_blitter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_pkg.sv
// Shared encodings and constants for the LT24 layer blitter.
package lt24_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_LO,
        S_CMD_HI,
        S_FETCH,
        S_WAIT,
        S_PIX_LO,
        S_PIX_HI,
        S_DONE
    } state_e;

    // ILI9341 memory-write command, sent once before the pixel stream
    localparam logic [15:0] CMD_RAMWR   = 16'h002C;
    localparam logic [15:0] KEY_DEFAULT = 16'hF81F;

endpackage

// File: rtl/lt24_phase_timer.sv
// Down-counter timing the wr low/high phases; load with (length - 1).
module lt24_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lt24_layer_blitter.sv
// Streams colour-keyed composited layer memory to an LT24 panel over the 8080 bus.
module lt24_layer_blitter
    import lt24_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int NUM_LAYERS = 2,
    parameter int CNT_W      = 17,
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter logic [DATA_W-1:0] KEY = DATA_W'(KEY_DEFAULT)
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_W-1:0]            start_base,
    input  logic [CNT_W-1:0]             start_count,
    output logic [ADDR_W-1:0]            mem_address,
    output logic                         mem_chipselect,
    output logic                         mem_clken,
    input  logic [NUM_LAYERS*DATA_W-1:0] mem_readdata,
    output logic                         lt24_cs,
    output logic                         lt24_rs,
    output logic                         lt24_rd,
    output logic                         lt24_wr,
    output logic [DATA_W-1:0]            lt24_data,
    output logic                         busy,
    output logic                         finish_flag,
    output logic [31:0]                  pix_counter
);

    localparam int PH_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int TW     = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              abort_q, abort_d;
    logic              tmr_load, tmr_done;
    logic [TW-1:0]     tmr_val;

    // Highest-index non-key layer wins; layer 0 shows through when all are keyed.
    function automatic logic [DATA_W-1:0] composite(input logic [NUM_LAYERS*DATA_W-1:0] rd);
        logic [DATA_W-1:0] px;
        px = rd[DATA_W-1:0];
        for (int i = 1; i < NUM_LAYERS; i++)
            if (rd[i*DATA_W +: DATA_W] != KEY)
                px = rd[i*DATA_W +: DATA_W];
        return px;
    endfunction

    lt24_phase_timer #(.W(TW)) u_timer (
        .clk_i      (clk_clk),
        .rst_i      (reset_reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            pix_q   <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        pix_d    = pix_q;
        data_d   = data_q;
        abort_d  = abort_q;
        tmr_load = 1'b0;
        tmr_val  = TW'(WR_LOW - 1);
        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start && !abort) begin
                    pix_d = '0;
                    if (start_count != '0) begin
                        base_d   = start_base;
                        count_d  = start_count;
                        data_d   = DATA_W'(CMD_RAMWR);
                        tmr_load = 1'b1;
                        state_d  = S_CMD_LO;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            // An abort seen during a low phase is held so the high phase still completes.
            S_CMD_LO, S_PIX_LO: begin
                abort_d = abort_q | abort;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(WR_HIGH - 1);
                    state_d  = (state_q == S_CMD_LO) ? S_CMD_HI : S_PIX_HI;
                end
            end
            S_CMD_HI: begin
                abort_d = abort_q | abort;
                if (tmr_done)
                    state_d = abort_d ? S_IDLE : S_FETCH;
            end
            S_FETCH: state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    data_d   = composite(mem_readdata);
                    tmr_load = 1'b1;
                    state_d  = S_PIX_LO;
                end
            end
            S_PIX_HI: begin
                abort_d = abort_q | abort;
                if (tmr_done) begin
                    pix_d = pix_q + CNT_W'(1);
                    if (abort_d)
                        state_d = S_IDLE;
                    else if (pix_d == count_q)
                        state_d = S_DONE;
                    else
                        state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign finish_flag    = (state_q == S_DONE);
    assign lt24_cs        = (state_q == S_IDLE) || (state_q == S_DONE);
    assign lt24_rs        = !((state_q == S_CMD_LO) || (state_q == S_CMD_HI));
    assign lt24_wr        = !((state_q == S_CMD_LO) || (state_q == S_PIX_LO));
    assign lt24_rd        = 1'b1;
    assign lt24_data      = data_q;
    assign mem_chipselect = (state_q == S_FETCH);
    assign mem_clken      = (state_q == S_FETCH);
    assign mem_address    = base_q + ADDR_W'(pix_q);
    assign pix_counter    = 32'(pix_q);

endmodule

// File: tb/tb_lt24_layer_blitter.sv
// Scoreboard bench: stimulus queues expected bus writes/addresses, monitors pop and compare.
module tb_lt24_layer_blitter;

    localparam logic [15:0] KEY = 16'hF81F;
    localparam logic [17:0] FIN = 18'h20000;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // DUT A: 2 layers, wr 2/2
    logic        a_start = 0, a_abort = 0;
    logic [12:0] a_base = 0;
    logic [16:0] a_cnt = 0;
    logic [12:0] a_addr;
    logic        a_csel, a_clken, a_cs, a_rs, a_rd, a_wr, a_busy, a_fin;
    logic [31:0] a_rdata = 0;
    logic [15:0] a_data;
    logic [31:0] a_pix;

    // DUT B: 4 layers, wr 1/3
    logic        b_start = 0, b_abort = 0;
    logic [12:0] b_base = 0;
    logic [16:0] b_cnt = 0;
    logic [12:0] b_addr;
    logic        b_csel, b_clken, b_cs, b_rs, b_rd, b_wr, b_busy, b_fin;
    logic [63:0] b_rdata = 0;
    logic [15:0] b_data;
    logic [31:0] b_pix;

    lt24_layer_blitter #(.ADDR_W(13), .DATA_W(16), .NUM_LAYERS(2), .CNT_W(17),
                         .WR_LOW(2), .WR_HIGH(2), .KEY(KEY)) dut_a (
        .clk_clk(clk), .reset_reset(rst), .start(a_start), .abort(a_abort),
        .start_base(a_base), .start_count(a_cnt), .mem_address(a_addr),
        .mem_chipselect(a_csel), .mem_clken(a_clken), .mem_readdata(a_rdata),
        .lt24_cs(a_cs), .lt24_rs(a_rs), .lt24_rd(a_rd), .lt24_wr(a_wr),
        .lt24_data(a_data), .busy(a_busy), .finish_flag(a_fin), .pix_counter(a_pix)
    );

    lt24_layer_blitter #(.ADDR_W(13), .DATA_W(16), .NUM_LAYERS(4), .CNT_W(17),
                         .WR_LOW(1), .WR_HIGH(3), .KEY(KEY)) dut_b (
        .clk_clk(clk), .reset_reset(rst), .start(b_start), .abort(b_abort),
        .start_base(b_base), .start_count(b_cnt), .mem_address(b_addr),
        .mem_chipselect(b_csel), .mem_clken(b_clken), .mem_readdata(b_rdata),
        .lt24_cs(b_cs), .lt24_rs(b_rs), .lt24_rd(b_rd), .lt24_wr(b_wr),
        .lt24_data(b_data), .busy(b_busy), .finish_flag(b_fin), .pix_counter(b_pix)
    );

    logic [31:0] mem_a [0:8191];
    logic [63:0] mem_b [0:7];

    always @(posedge clk) begin
        if (a_csel) a_rdata <= mem_a[a_addr];
        if (b_csel) b_rdata <= mem_b[b_addr[2:0]];
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void miss(string nm, logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing queued", nm, act);
    endfunction

    // Expected events: {fin, rs, data}; expected fetch addresses
    logic [17:0] qa_ev[$], qb_ev[$];
    logic [12:0] qa_ad[$], qb_ad[$];

    bit a_wprev = 1, a_hrun = 0, b_wprev = 1, b_hrun = 0;
    int a_lo = 0, a_hi = 0, b_lo = 0, b_hi = 0;

    always @(negedge clk) begin
        if (rst) begin
            a_wprev = 1; a_hrun = 0;
        end else begin
            if (a_csel) begin
                chk("a clken", 32'(a_clken), 32'd1);
                if (qa_ad.size() == 0) miss("a addr", 32'(a_addr));
                else chk("a addr", 32'(a_addr), 32'(qa_ad.pop_front()));
            end
            if (!a_wr) begin
                a_lo = a_wprev ? 1 : a_lo + 1;
            end else if (!a_wprev) begin
                if (qa_ev.size() == 0) miss("a write", 32'({a_rs, a_data}));
                else chk("a write", 32'({1'b0, a_rs, a_data}), 32'(qa_ev.pop_front()));
                chk("a cs in write", 32'(a_cs), 32'd0);
                chk("a rd", 32'(a_rd), 32'd1);
                chk("a wr low width", 32'(a_lo), 32'd2);
                a_hrun = 1; a_hi = 1;
            end else if (a_hrun) begin
                if (a_cs || a_csel) begin
                    chk("a wr high width", 32'(a_hi), 32'd2);
                    a_hrun = 0;
                end else a_hi++;
            end
            if (a_fin) begin
                chk("a busy at fin", 32'(a_busy), 32'd1);
                if (qa_ev.size() == 0) miss("a finish", 32'(FIN));
                else chk("a finish", 32'(FIN), 32'(qa_ev.pop_front()));
            end
            a_wprev = a_wr;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_wprev = 1; b_hrun = 0;
        end else begin
            if (b_csel) begin
                if (qb_ad.size() == 0) miss("b addr", 32'(b_addr));
                else chk("b addr", 32'(b_addr), 32'(qb_ad.pop_front()));
            end
            if (!b_wr) begin
                b_lo = b_wprev ? 1 : b_lo + 1;
            end else if (!b_wprev) begin
                if (qb_ev.size() == 0) miss("b write", 32'({b_rs, b_data}));
                else chk("b write", 32'({1'b0, b_rs, b_data}), 32'(qb_ev.pop_front()));
                chk("b wr low width", 32'(b_lo), 32'd1);
                b_hrun = 1; b_hi = 1;
            end else if (b_hrun) begin
                if (b_cs || b_csel) begin
                    chk("b wr high width", 32'(b_hi), 32'd3);
                    b_hrun = 0;
                end else b_hi++;
            end
            if (b_fin) begin
                if (qb_ev.size() == 0) miss("b finish", 32'(FIN));
                else chk("b finish", 32'(FIN), 32'(qb_ev.pop_front()));
            end
            b_wprev = b_wr;
        end
    end

    // Starts A from a negedge and counts busy clocks; poke re-pulses start mid-transfer.
    task automatic run_a(input logic [12:0] base, input logic [16:0] cnt, input bit poke,
                         output int bc);
        a_base = base; a_cnt = cnt; a_start = 1;
        @(negedge clk);
        a_start = 0; a_base = 13'd100; a_cnt = 17'd1;
        bc = 0;
        while (a_busy && bc < 400) begin
            bc++;
            a_start = poke && (bc == 10);
            @(negedge clk);
        end
        a_start = 0;
    endtask

    task automatic exp_a3();
        qa_ev.push_back({2'b00, 16'h002C});
        qa_ev.push_back({2'b01, 16'hAAAA});
        qa_ev.push_back({2'b01, 16'h1234});
        qa_ev.push_back({2'b01, 16'hCCCC});
        qa_ev.push_back(FIN);
        qa_ad.push_back(13'd0); qa_ad.push_back(13'd1); qa_ad.push_back(13'd2);
    endtask

    initial begin
        int bc;
        for (int i = 0; i < 8192; i++) mem_a[i] = '0;
        mem_a[0]    = {KEY, 16'hAAAA};
        mem_a[1]    = {16'h1234, 16'hBBBB};
        mem_a[2]    = {KEY, 16'hCCCC};
        mem_a[8190] = {KEY, 16'h1111};
        mem_a[8191] = {16'h2222, 16'h3333};
        for (int i = 0; i < 8; i++) mem_b[i] = '0;
        mem_b[0] = {KEY, KEY, KEY, KEY};
        mem_b[1] = {KEY, 16'h2222, 16'h1111, 16'h0000};
        mem_b[2] = {KEY, KEY, KEY, 16'h0B0B};
        mem_b[3] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};

        repeat (3) @(negedge clk);
        chk("rst cs", 32'(a_cs), 32'd1);
        chk("rst rs", 32'(a_rs), 32'd1);
        chk("rst rd", 32'(a_rd), 32'd1);
        chk("rst wr", 32'(a_wr), 32'd1);
        chk("rst data", 32'(a_data), 32'd0);
        chk("rst addr", 32'(a_addr), 32'd0);
        chk("rst chipselect", 32'(a_csel), 32'd0);
        chk("rst clken", 32'(a_clken), 32'd0);
        chk("rst busy", 32'(a_busy), 32'd0);
        chk("rst finish", 32'(a_fin), 32'd0);
        chk("rst pix", a_pix, 32'd0);
        chk("rst b wr", 32'(b_wr), 32'd1);
        chk("rst b cs", 32'(b_cs), 32'd1);
        rst = 0;
        @(negedge clk);

        // Basic 3-pixel composite
        exp_a3();
        run_a(13'd0, 17'd3, 1'b0, bc);
        chk("s1 busy clocks", 32'(bc), 32'd23);
        chk("s1 pix", a_pix, 32'd3);

        // Address wrap, with an ignored start while busy
        qa_ev.push_back({2'b00, 16'h002C});
        qa_ev.push_back({2'b01, 16'h1111});
        qa_ev.push_back({2'b01, 16'h2222});
        qa_ev.push_back({2'b01, 16'hAAAA});
        qa_ev.push_back({2'b01, 16'h1234});
        qa_ev.push_back(FIN);
        qa_ad.push_back(13'd8190); qa_ad.push_back(13'd8191);
        qa_ad.push_back(13'd0);    qa_ad.push_back(13'd1);
        run_a(13'd8190, 17'd4, 1'b1, bc);
        chk("wrap busy clocks", 32'(bc), 32'd29);
        chk("wrap pix", a_pix, 32'd4);

        // Zero count: DONE only
        qa_ev.push_back(FIN);
        a_cnt = 17'd0; a_start = 1;
        @(negedge clk);
        a_start = 0;
        chk("c0 busy", 32'(a_busy), 32'd1);
        chk("c0 cs", 32'(a_cs), 32'd1);
        chk("c0 wr", 32'(a_wr), 32'd1);
        chk("c0 finish", 32'(a_fin), 32'd1);
        @(negedge clk);
        chk("c0 idle", 32'(a_busy), 32'd0);
        chk("c0 finish low", 32'(a_fin), 32'd0);

        // Abort with start in IDLE
        a_base = 0; a_cnt = 17'd3; a_start = 1; a_abort = 1;
        @(negedge clk);
        a_start = 0; a_abort = 0;
        chk("abort+start idle", 32'(a_busy), 32'd0);

        // Abort during the second PIX_LO
        qa_ev.push_back({2'b00, 16'h002C});
        qa_ev.push_back({2'b01, 16'hAAAA});
        qa_ev.push_back({2'b01, 16'h1234});
        qa_ad.push_back(13'd0); qa_ad.push_back(13'd1);
        a_base = 0; a_cnt = 17'd3; a_start = 1;
        @(negedge clk);
        a_start = 0;
        bc = 0;
        while (!(a_wr == 1'b0 && a_rs == 1'b1 && a_pix == 32'd1) && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        chk("abort reached pix_lo 2", 32'(bc < 200), 32'd1);
        a_abort = 1;
        @(negedge clk);
        a_abort = 0;
        bc = 0;
        while (a_busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        chk("abort tail clocks", 32'(bc), 32'd3);
        chk("abort pix", a_pix, 32'd2);
        repeat (2) @(negedge clk);
        chk("abort queue drained", 32'(qa_ev.size() + qa_ad.size()), 32'd0);

        // Reset mid-PIX_LO, then a normal transfer
        qa_ev.push_back({2'b00, 16'h002C});
        qa_ad.push_back(13'd0);
        a_base = 0; a_cnt = 17'd3; a_start = 1;
        @(negedge clk);
        a_start = 0;
        bc = 0;
        while (!(a_wr == 1'b0 && a_rs == 1'b1) && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        rst = 1;
        #1;
        chk("mid rst wr", 32'(a_wr), 32'd1);
        chk("mid rst cs", 32'(a_cs), 32'd1);
        chk("mid rst busy", 32'(a_busy), 32'd0);
        chk("mid rst pix", a_pix, 32'd0);
        chk("mid rst queue", 32'(qa_ev.size() + qa_ad.size()), 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        exp_a3();
        run_a(13'd0, 17'd3, 1'b0, bc);
        chk("post rst busy clocks", 32'(bc), 32'd23);
        chk("post rst pix", a_pix, 32'd3);

        // 4 layers, wr 1/3
        qb_ev.push_back({2'b00, 16'h002C});
        qb_ev.push_back({2'b01, KEY});
        qb_ev.push_back({2'b01, 16'h2222});
        qb_ev.push_back({2'b01, 16'h0B0B});
        qb_ev.push_back({2'b01, 16'h3333});
        qb_ev.push_back(FIN);
        for (int i = 0; i < 4; i++) qb_ad.push_back(13'(i));
        b_base = 0; b_cnt = 17'd4; b_start = 1;
        @(negedge clk);
        b_start = 0;
        bc = 0;
        while (b_busy && bc < 400) begin
            bc++;
            @(negedge clk);
        end
        chk("b busy clocks", 32'(bc), 32'd29);
        chk("b pix", b_pix, 32'd4);

        repeat (3) @(negedge clk);
        chk("a leftover", 32'(qa_ev.size() + qa_ad.size()), 32'd0);
        chk("b leftover", 32'(qb_ev.size() + qb_ad.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
